// File: rtl/tabla_inst_pkg.sv
// tabla_inst_pkg
// Shared definitions for the per-PE instruction path: instruction field widths
// (shared with the instruction field splitter) and the sequencer state encoding.
package tabla_inst_pkg;

    localparam int unsigned FN_LEN    = 3;
    localparam int unsigned NAME_LEN  = 3;
    localparam int unsigned INDEX_LEN = 8;
    // One function field plus six (name, index) operand pairs.
    localparam int unsigned INST_LEN  = FN_LEN + 6 * (NAME_LEN + INDEX_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/inst_mem.sv
// inst_mem
// Instruction store: depth x width, one write port and one synchronous read port
// (read-before-write on an address collision), written to map onto block RAM.
// Ports:
//   clk      - rising-edge clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every cycle
//   rd_data  - registered read data (contents of rd_addr from the previous edge)
module inst_mem
    import tabla_inst_pkg::*;
#(
    parameter int unsigned depth    = 256,
    parameter int unsigned width    = INST_LEN,
    parameter int unsigned addr_len = 8
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [addr_len-1:0] wr_addr,
    input  logic [width-1:0]    wr_data,
    input  logic [addr_len-1:0] rd_addr,
    output logic [width-1:0]    rd_data
);

    logic [width-1:0] mem [depth];

    // No reset on the array or the read register so this infers block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer
// Per-PE instruction store and program sequencer. A program is loaded one word
// per cycle while idle; on start it is replayed iteration times, one registered
// instruction word plus valid qualifier per cycle, honouring downstream stall.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   prog_clear   - idle only: empty the program
//   load_en      - idle only: append load_data to the program
//   load_data    - program word
//   start        - idle only: begin execution (ignored with an empty program)
//   iter_in      - iteration count latched on start, 0 runs once
//   stall        - downstream hold request
//   instword     - current instruction (registered)
//   instword_v   - instruction valid
//   pc           - address of the next word to issue
//   prog_len     - number of loaded words
//   load_full    - program store full
//   busy         - running
//   done         - one-cycle pulse at program completion
module inst_sequencer
    import tabla_inst_pkg::*;
#(
    parameter int unsigned fnLen    = FN_LEN,
    parameter int unsigned nameLen  = NAME_LEN,
    parameter int unsigned indexLen = INDEX_LEN,
    parameter int unsigned memDepth = 256,
    parameter int unsigned addrLen  = 8,
    parameter int unsigned iterLen  = 16,
    localparam int unsigned instLen = fnLen + 6 * (nameLen + indexLen)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_clear,
    input  logic               load_en,
    input  logic [instLen-1:0] load_data,
    input  logic               start,
    input  logic [iterLen-1:0] iter_in,
    input  logic               stall,
    output logic [instLen-1:0] instword,
    output logic               instword_v,
    output logic [addrLen-1:0] pc,
    output logic [addrLen:0]   prog_len,
    output logic               load_full,
    output logic               busy,
    output logic               done
);

    localparam logic [addrLen-1:0] PcOne   = addrLen'(1);
    localparam logic [addrLen:0]   LenOne  = (addrLen + 1)'(1);
    localparam logic [addrLen:0]   LenFull = (addrLen + 1)'(memDepth);
    localparam logic [iterLen-1:0] IterOne = iterLen'(1);

    seq_state_t         state_q, state_d;
    logic [addrLen-1:0] pc_q, pc_d;
    logic [addrLen:0]   prog_len_q, prog_len_d;
    logic [iterLen-1:0] iters_q, iters_d;
    logic [iterLen-1:0] iter_cnt_q, iter_cnt_d;
    logic [instLen-1:0] instword_q, instword_d;
    logic               instword_v_q, instword_v_d;

    logic               mem_we;
    logic [instLen-1:0] mem_rd_data;
    logic               full;
    logic               last_word;
    logic               last_iter;

    assign full      = (prog_len_q == LenFull);
    assign last_word = ({1'b0, pc_q} == (prog_len_q - LenOne));
    assign last_iter = (iter_cnt_q == (iters_q - IterOne));

    // The RAM is addressed with the next PC, so its registered output already
    // holds mem[pc] during the cycle in which pc is issued. This keeps the
    // start-to-first-word latency at two cycles while the output register
    // stays here. During a stall pc_d == pc_q, so the same word is re-read.
    inst_mem #(
        .depth    (memDepth),
        .width    (instLen),
        .addr_len (addrLen)
    ) u_inst_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (prog_len_q[addrLen-1:0]),
        .wr_data (load_data),
        .rd_addr (pc_d),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        prog_len_d   = prog_len_q;
        iters_d      = iters_q;
        iter_cnt_d   = iter_cnt_q;
        instword_d   = instword_q;
        instword_v_d = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (prog_clear) begin
                    prog_len_d = '0;
                end else if (load_en) begin
                    // A load into a full store is dropped; start is ignored too.
                    if (!full) begin
                        mem_we     = 1'b1;
                        prog_len_d = prog_len_q + LenOne;
                    end
                end else if (start && (prog_len_q != '0)) begin
                    iters_d    = (iter_in == '0) ? IterOne : iter_in;
                    pc_d       = '0;
                    iter_cnt_d = '0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (!stall) begin
                    instword_d   = mem_rd_data;
                    instword_v_d = 1'b1;
                    if (last_word) begin
                        pc_d = '0;
                        if (last_iter) begin
                            state_d = DONE;
                        end else begin
                            // Wrap straight to word 0: no bubble between iterations.
                            iter_cnt_d = iter_cnt_q + IterOne;
                        end
                    end else begin
                        pc_d = pc_q + PcOne;
                    end
                end
            end

            DONE: begin
                pc_d    = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            prog_len_q   <= '0;
            iters_q      <= IterOne;
            iter_cnt_q   <= '0;
            instword_q   <= '0;
            instword_v_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prog_len_q   <= prog_len_d;
            iters_q      <= iters_d;
            iter_cnt_q   <= iter_cnt_d;
            instword_q   <= instword_d;
            instword_v_q <= instword_v_d;
        end
    end

    assign instword   = instword_q;
    assign instword_v = instword_v_q;
    assign pc         = pc_q;
    assign prog_len   = prog_len_q;
    assign load_full  = full;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer
// Self-checking bench for inst_sequencer. Expected instruction words are pushed
// to a queue when start is driven and popped by a monitor on every valid word.
module tb_inst_sequencer;

    localparam int W = 69;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_clear;
    logic          load_en;
    logic [W-1:0]  load_data;
    logic          start;
    logic [15:0]   iter_in;
    logic          stall;
    logic [W-1:0]  instword;
    logic          instword_v;
    logic [7:0]    pc;
    logic [8:0]    prog_len;
    logic          load_full;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] model [256];
    int           model_len = 0;

    inst_sequencer u_dut (
        .clk        (clk),
        .reset      (reset),
        .prog_clear (prog_clear),
        .load_en    (load_en),
        .load_data  (load_data),
        .start      (start),
        .iter_in    (iter_in),
        .stall      (stall),
        .instword   (instword),
        .instword_v (instword_v),
        .pc         (pc),
        .prog_len   (prog_len),
        .load_full  (load_full),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid word must match the head of the queue.
    always @(negedge clk) begin
        if (instword_v === 1'b1) begin
            check_eq("word_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                check_eq("instword", instword, exp_q.pop_front());
            end
        end
    end

    function automatic logic [W-1:0] make_word(input int i, input int salt);
        return {5'(salt), 64'(i + 1) ^ (64'(salt) << 32)};
    endfunction

    task automatic load_words(input int n, input int salt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_data = make_word(i, salt);
            if (model_len < 256) begin
                model[model_len] = load_data;
                model_len++;
            end
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clear_prog();
        @(negedge clk);
        prog_clear = 1'b1;
        @(negedge clk);
        prog_clear = 1'b0;
        model_len  = 0;
    endtask

    // Drive start in cycle T and follow the run cycle by cycle. Optional stall
    // window [stall_at, stall_at+stall_len) counted in cycles after T; poke
    // pulses the idle-only controls during RUN.
    task automatic run_prog(input int k, input int stall_at, input int stall_len, input bit poke);
        int n;
        int k_eff;
        int done_cyc;
        n        = model_len;
        k_eff    = (k == 0) ? 1 : k;
        done_cyc = 1 + n * k_eff + stall_len;
        @(negedge clk);
        start   = 1'b1;
        iter_in = 16'(k);
        for (int it = 0; it < k_eff; it++) begin
            for (int w = 0; w < n; w++) begin
                exp_q.push_back(model[w]);
            end
        end
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            check_eq("busy", W'(busy), W'(c < done_cyc));
            check_eq("done", W'(done), W'(c == done_cyc));
            if (c == done_cyc) begin
                check_eq("last_valid_with_done", W'(instword_v), W'(1));
            end
            if (stall_len > 0 && c > stall_at && c <= stall_at + stall_len) begin
                check_eq("stall_bubble", W'(instword_v), W'(0));
                check_eq("stall_hold", instword, model[stall_at - 2]);
            end
            stall = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
            if (poke) begin
                prog_clear = (c == 2);
                load_en    = (c == 2);
                start      = (c == 2);
                load_data  = {W{1'b1}};
            end
        end
        load_en    = 1'b0;
        prog_clear = 1'b0;
        start      = 1'b0;
        check_eq("queue_drained", W'(exp_q.size()), W'(0));
        check_eq("prog_len_kept", W'(prog_len), W'(model_len));
    endtask

    initial begin
        reset      = 1'b1;
        prog_clear = 1'b0;
        load_en    = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        iter_in    = '0;
        stall      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_instword", instword, '0);
        check_eq("rst_instword_v", W'(instword_v), W'(0));
        check_eq("rst_pc", W'(pc), W'(0));
        check_eq("rst_prog_len", W'(prog_len), W'(0));
        check_eq("rst_load_full", W'(load_full), W'(0));
        check_eq("rst_busy", W'(busy), W'(0));
        check_eq("rst_done", W'(done), W'(0));
        reset = 1'b0;

        // 4 words, one iteration.
        load_words(4, 0);
        check_eq("prog_len_4", W'(prog_len), W'(4));
        run_prog(1, 0, 0, 1'b0);

        // 3 words, two iterations back to back.
        clear_prog();
        check_eq("cleared_len", W'(prog_len), W'(0));
        load_words(3, 1);
        run_prog(2, 0, 0, 1'b0);

        // Two-cycle stall after the 2nd of 4 words.
        clear_prog();
        load_words(4, 2);
        run_prog(1, 3, 2, 1'b0);

        // Re-run retained program, stall on the last-word cycle.
        run_prog(1, 4, 1, 1'b0);

        // Idle-only controls pulsed during RUN, two iterations.
        run_prog(2, 0, 0, 1'b1);

        // iter_in = 0 runs once.
        clear_prog();
        load_words(2, 3);
        run_prog(0, 0, 0, 1'b0);

        // Reset mid-RUN after 2 words.
        clear_prog();
        load_words(4, 4);
        @(negedge clk);
        start   = 1'b1;
        iter_in = 16'd1;
        for (int w = 0; w < 4; w++) exp_q.push_back(model[w]);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_instword_v", W'(instword_v), W'(0));
        check_eq("midrst_instword", instword, '0);
        check_eq("midrst_pc", W'(pc), W'(0));
        check_eq("midrst_prog_len", W'(prog_len), W'(0));
        check_eq("midrst_busy", W'(busy), W'(0));
        check_eq("midrst_done", W'(done), W'(0));
        reset = 1'b0;
        exp_q.delete();
        model_len = 0;

        // Fill the store to the brim, then one extra load.
        load_words(255, 5);
        check_eq("len_255", W'(prog_len), W'(255));
        check_eq("not_full_255", W'(load_full), W'(0));
        load_words(1, 6);
        check_eq("len_256", W'(prog_len), W'(256));
        check_eq("full_256", W'(load_full), W'(1));
        load_words(1, 7);
        check_eq("len_stays_256", W'(prog_len), W'(256));
        check_eq("full_stays", W'(load_full), W'(1));
        run_prog(1, 0, 0, 1'b0);

        // start with an empty program is ignored.
        clear_prog();
        @(negedge clk);
        start   = 1'b1;
        iter_in = 16'd1;
        @(negedge clk);
        start = 1'b0;
        check_eq("empty_start_busy", W'(busy), W'(0));
        check_eq("empty_start_len", W'(prog_len), W'(0));
        @(negedge clk);
        check_eq("empty_start_valid", W'(instword_v), W'(0));
        check_eq("empty_start_busy2", W'(busy), W'(0));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
